// File: rtl/ddr3_dma_pkg.sv
// Shared types and widths for the DDR3 read DMA arbitration path.
package ddr3_dma_pkg;

   localparam int DDR_ADDR_W = 27;
   localparam int DDR_LEN_W  = 27;
   localparam int N_RD_CH    = 16;
   localparam int ID_W       = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } arb_state_t;

   // Increment a channel index, wrapping at n (n need not be a power of two).
   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id, input int n);
      return (int'(id) == n - 1) ? '0 : id + 1'b1;
   endfunction

endpackage

// File: rtl/ddr3_dma_rr_pick.sv
// Combinational round-robin picker: first set eligible bit at or after ptr_i, wrapping.
module ddr3_dma_rr_pick
   import ddr3_dma_pkg::*;
#(
   parameter int N_CH = N_RD_CH
) (
   input  logic [N_CH-1:0] eligible_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic            found_o,
   output logic [ID_W-1:0] idx_o
);

   logic [2*N_CH-1:0] dbl;
   logic [N_CH-1:0]   rot;
   logic [ID_W-1:0]   off;
   logic [ID_W:0]     sum;

   always_comb begin
      dbl     = {eligible_i, eligible_i};
      rot     = '0;
      found_o = 1'b0;
      off     = '0;
      sum     = '0;
      idx_o   = '0;
      // Rotate so the pointer position lands at bit 0.
      for (int i = 0; i < N_CH; i++) begin
         rot[i] = dbl[i + int'(ptr_i)];
      end
      // Descending scan leaves the lowest set offset as the winner.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found_o = 1'b1;
            off     = ID_W'(i);
         end
      end
      sum = {1'b0, ptr_i} + {1'b0, off};
      if (sum >= (ID_W+1)'(N_CH)) begin
         sum = sum - (ID_W+1)'(N_CH);
      end
      idx_o = sum[ID_W-1:0];
   end

endmodule

// File: rtl/ddr3_dma_read_arbiter.sv
// Round-robin scheduler sharing one DDR3 read DMA engine among up to 16 requesters.
module ddr3_dma_read_arbiter
   import ddr3_dma_pkg::*;
#(
   parameter int N_CH   = N_RD_CH,
   parameter int ADDR_W = DDR_ADDR_W,
   parameter int LEN_W  = DDR_LEN_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          read_req,
   input  logic [N_CH*ADDR_W-1:0]   read_start_addr,
   input  logic [N_CH*LEN_W-1:0]    read_length,
   output logic [N_CH-1:0]          read_ack,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [ADDR_W-1:0]        cmd_addr,
   output logic [LEN_W-1:0]         cmd_length,
   output logic [3:0]               cmd_id,
   input  logic                     rd_done,
   output logic                     busy
);

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   mask_id_q, mask_id_d;
   logic              mask_vld_q, mask_vld_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [N_CH-1:0]   ack_q, ack_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              busy_q, busy_d;

   logic [N_CH-1:0]   mask_vec;
   logic [N_CH-1:0]   eligible;
   logic              pick_found;
   logic [ID_W-1:0]   pick_idx;
   logic [ADDR_W-1:0] grant_addr;
   logic [LEN_W-1:0]  grant_len;

   // The last acked channel is hidden for the single IDLE cycle after its ack.
   always_comb begin
      mask_vec = '0;
      if (mask_vld_q) begin
         mask_vec[mask_id_q] = 1'b1;
      end
      eligible = read_req & ~mask_vec;
   end

   ddr3_dma_rr_pick #(
      .N_CH (N_CH)
   ) u_pick (
      .eligible_i (eligible),
      .ptr_i      (rr_ptr_q),
      .found_o    (pick_found),
      .idx_o      (pick_idx)
   );

   assign grant_addr = read_start_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
   assign grant_len  = read_length[int'(pick_idx)*LEN_W +: LEN_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = (grant_len != '0) ? ISSUE : ACK;
            end
         end
         ISSUE: begin
            if (cmd_valid_q && cmd_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (rd_done) begin
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs and the latched grant context.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      mask_id_d   = mask_id_q;
      mask_vld_d  = mask_vld_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      ack_d       = '0;
      if (state_q == IDLE) begin
         mask_vld_d = 1'b0;
         if (pick_found) begin
            id_d   = pick_idx;
            addr_d = grant_addr;
            len_d  = grant_len;
         end
      end
      if (state_q == ACK) begin
         rr_ptr_d   = wrap_inc(id_q, N_CH);
         mask_id_d  = id_q;
         mask_vld_d = 1'b1;
      end
      if (state_d == ACK) begin
         ack_d[id_d] = 1'b1;
      end
      cmd_valid_d = (state_d == ISSUE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q    <= '0;
         mask_id_q   <= '0;
         mask_vld_q  <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         ack_q       <= '0;
         cmd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         mask_id_q   <= mask_id_d;
         mask_vld_q  <= mask_vld_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         ack_q       <= ack_d;
         cmd_valid_q <= cmd_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign read_ack   = ack_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_addr   = addr_q;
   assign cmd_length = len_q;
   assign cmd_id     = id_q;
   assign busy       = busy_q;

endmodule
